// File: rtl/guess_judge.sv
// Number-guessing judge: draws a secret from a free-running LFSR, grades each submitted
// guess as too high / too low / correct / invalid and counts attempts up to a try limit.
module guess_judge #(
   parameter int unsigned MAX_VAL   = 99,
   parameter int unsigned MAX_TRIES = 7,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enter,
   input  logic [7:0] datain,
   input  logic       new_game,
   output logic       too_high,
   output logic       too_low,
   output logic       correct,
   output logic       invalid,
   output logic       game_over,
   output logic [3:0] tries,
   output logic [7:0] secret
);

   localparam logic [7:0] MaxVal   = 8'(MAX_VAL);
   localparam logic [3:0] MaxTries = 4'(MAX_TRIES);

   typedef enum logic [1:0] {StDraw, StWait, StWin, StLose} state_t;

   state_t     state;
   logic [7:0] lfsr;
   logic [7:0] lfsr_nxt;
   logic [7:0] draw_v;
   logic       enter_q1;
   logic       enter_q2;
   logic       submit;
   logic [3:0] tries_inc;

   // x^8+x^6+x^5+x^4+1 is primitive, so a non-zero seed never reaches the all-zero state
   always_comb begin
      lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      draw_v    = {1'b0, lfsr[6:0]};
      submit    = enter_q1 & ~enter_q2;
      tries_inc = tries + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StDraw;
         lfsr      <= LFSR_SEED;
         enter_q1  <= 1'b0;
         enter_q2  <= 1'b0;
         too_high  <= 1'b0;
         too_low   <= 1'b0;
         correct   <= 1'b0;
         invalid   <= 1'b0;
         game_over <= 1'b0;
         tries     <= 4'd0;
         secret    <= 8'd0;
      end else begin
         lfsr     <= lfsr_nxt;
         enter_q1 <= enter;
         enter_q2 <= enter_q1;
         // new_game wins over any submit in the same cycle; outputs hold until the redraw
         if (new_game) begin
            state <= StDraw;
         end else begin
            case (state)
               StDraw: begin
                  // rejection sampling keeps the secret uniform over 1..MAX_VAL
                  if (draw_v != 8'd0 && draw_v <= MaxVal) begin
                     secret    <= draw_v;
                     tries     <= 4'd0;
                     too_high  <= 1'b0;
                     too_low   <= 1'b0;
                     correct   <= 1'b0;
                     invalid   <= 1'b0;
                     game_over <= 1'b0;
                     state     <= StWait;
                  end
               end
               StWait: begin
                  if (submit) begin
                     if (datain == 8'd0 || datain > MaxVal) begin
                        invalid  <= 1'b1;
                        too_high <= 1'b0;
                        too_low  <= 1'b0;
                     end else if (datain == secret) begin
                        correct  <= 1'b1;
                        invalid  <= 1'b0;
                        too_high <= 1'b0;
                        too_low  <= 1'b0;
                        tries    <= tries_inc;
                        state    <= StWin;
                     end else begin
                        too_high <= datain > secret;
                        too_low  <= datain < secret;
                        invalid  <= 1'b0;
                        tries    <= tries_inc;
                        if (tries_inc == MaxTries) begin
                           game_over <= 1'b1;
                           state     <= StLose;
                        end
                     end
                  end
               end
               StWin, StLose: ;
               default: state <= StDraw;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_guess_judge.sv
// Bench for guess_judge: directed test-plan steps followed by random play, every cycle
// compared against a game-level reference model.
module tb_guess_judge;

   localparam int MaxVal   = 99;
   localparam int MaxTries = 7;
   localparam int Seed     = 8'hA5;

   logic       clk = 1'b0;
   logic       rst;
   logic       enter;
   logic [7:0] datain;
   logic       new_game;
   logic       too_high;
   logic       too_low;
   logic       correct;
   logic       invalid;
   logic       game_over;
   logic [3:0] tries;
   logic [7:0] secret;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model: phase 0 drawing, 1 playing, 2 won, 3 lost
   int m_lfsr, m_ph, m_sec, m_tries;
   bit m_hi, m_lo, m_ok, m_inv, m_go;
   bit e_prev1, e_prev2;

   guess_judge dut (
      .clk      (clk),
      .rst      (rst),
      .enter    (enter),
      .datain   (datain),
      .new_game (new_game),
      .too_high (too_high),
      .too_low  (too_low),
      .correct  (correct),
      .invalid  (invalid),
      .game_over(game_over),
      .tries    (tries),
      .secret   (secret)
   );

   always #5 clk = ~clk;

   function automatic int lfsr_next(input int l);
      int fb;
      fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
      return ((l << 1) & 255) | fb;
   endfunction

   task automatic model_edge(input bit r, input bit en, input bit ng, input int d);
      bit sub;
      int v;
      if (r) begin
         m_lfsr = Seed; m_ph = 0; m_sec = 0; m_tries = 0;
         m_hi = 0; m_lo = 0; m_ok = 0; m_inv = 0; m_go = 0;
         e_prev1 = 0; e_prev2 = 0;
         return;
      end
      sub = e_prev1 && !e_prev2;
      e_prev2 = e_prev1;
      e_prev1 = en;
      v = m_lfsr % 128;
      if (ng) m_ph = 0;
      else if (m_ph == 0) begin
         if (v >= 1 && v <= MaxVal) begin
            m_sec = v; m_tries = 0; m_ph = 1;
            m_hi = 0; m_lo = 0; m_ok = 0; m_inv = 0; m_go = 0;
         end
      end else if (m_ph == 1 && sub) begin
         if (d == 0 || d > MaxVal) begin
            m_inv = 1; m_hi = 0; m_lo = 0;
         end else if (d == m_sec) begin
            m_ok = 1; m_inv = 0; m_hi = 0; m_lo = 0; m_tries++; m_ph = 2;
         end else begin
            m_hi = d > m_sec; m_lo = d < m_sec; m_inv = 0; m_tries++;
            if (m_tries == MaxTries) begin
               m_go = 1; m_ph = 3;
            end
         end
      end
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("too_high", int'(too_high), int'(m_hi));
      chk("too_low", int'(too_low), int'(m_lo));
      chk("correct", int'(correct), int'(m_ok));
      chk("invalid", int'(invalid), int'(m_inv));
      chk("game_over", int'(game_over), int'(m_go));
      chk("tries", int'(tries), m_tries);
      chk("secret", int'(secret), m_sec);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(rst, enter, new_game, int'(datain));
      #1;
      compare_all();
   endtask

   task automatic guess(input int g);
      datain = 8'(g);
      enter  = 1'b1;
      step();
      step();
      enter = 1'b0;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("reset_secret", int'(secret), 37);
   endtask

   task automatic wait_draw();
      int n = 0;
      while (m_ph != 1 && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) begin
         n_fail++;
         $display("FAIL draw_timeout: observed no draw in %0d cycles, expected one", n);
      end
   endtask

   task automatic pulse_new_game();
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      wait_draw();
   endtask

   initial begin
      rst = 1'b1; enter = 1'b0; new_game = 1'b0; datain = 8'd0;
      step();
      chk("rst_tries", int'(tries), 0);
      chk("rst_secret", int'(secret), 0);
      chk("rst_flags", int'({too_high, too_low, correct, invalid, game_over}), 0);
      rst = 1'b0;
      step();
      chk("first_secret", int'(secret), 37);
      chk("first_tries", int'(tries), 0);

      // invalid guesses leave tries alone
      guess(0);
      chk("inv0", int'(invalid), 1);
      chk("inv0_tries", int'(tries), 0);
      guess(120);
      chk("inv120", int'(invalid), 1);
      chk("inv120_tries", int'(tries), 0);
      guess(36);
      chk("low36", int'({too_low, invalid}), 2);
      chk("low36_tries", int'(tries), 1);
      guess(50);
      chk("high50", int'(too_high), 1);
      chk("high50_tries", int'(tries), 2);
      guess(20);
      chk("low20", int'(too_low), 1);
      chk("low20_tries", int'(tries), 3);
      guess(37);
      chk("win37", int'({correct, too_high, too_low}), 4);
      chk("win37_tries", int'(tries), 4);
      guess(10);
      chk("after_win", int'({correct, too_high, too_low, invalid}), 8);
      chk("after_win_tries", int'(tries), 4);

      // exhaust the tries
      do_reset();
      for (int g = 1; g <= 6; g++) guess(g);
      chk("six_tries", int'(tries), 6);
      guess(99);
      chk("lose_go", int'(game_over), 1);
      chk("lose_high", int'(too_high), 1);
      chk("lose_tries", int'(tries), 7);
      guess(37);
      chk("lose_hold", int'({game_over, correct}), 2);
      pulse_new_game();
      chk("ng_tries", int'(tries), 0);
      chk("ng_flags", int'({too_high, too_low, correct, invalid, game_over}), 0);
      chk("ng_range", int'(secret >= 8'd1 && secret <= 8'd99), 1);

      // a correct guess on the last try wins
      do_reset();
      for (int g = 1; g <= 6; g++) guess(g);
      guess(37);
      chk("last_win", int'({correct, game_over}), 2);
      chk("last_win_tries", int'(tries), 7);

      // held enter submits once
      pulse_new_game();
      datain = 8'd40;
      enter  = 1'b1;
      repeat (20) step();
      enter = 1'b0;
      step();
      chk("held_tries", int'(tries), 1);

      // new_game coinciding with a submit discards the guess
      if (m_ph == 1) begin
         datain = 8'd41;
         enter  = 1'b1;
         step();
         new_game = 1'b1;
         step();
         new_game = 1'b0;
         enter    = 1'b0;
         chk("ng_discard_tries", int'(tries), 1);
         wait_draw();
         chk("ng_discard_redraw", int'(tries), 0);
      end

      // reset in mid-game
      do_reset();
      for (int g = 1; g <= 4; g++) guess(g);
      chk("mid_tries", int'(tries), 4);
      chk("mid_low", int'(too_low), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_out", int'({too_high, too_low, correct, invalid, game_over, tries, secret}), 0);
      step();
      chk("mid_rst_secret", int'(secret), 37);

      // random play
      for (int i = 0; i < 3000; i++) begin
         int d;
         rst      = ($urandom_range(0, 399) == 0);
         new_game = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 2) == 0) enter = ~enter;
         if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 255);
         else begin
            d = m_sec + int'($urandom_range(0, 6)) - 3;
            if (d < 0) d = 0;
         end
         datain = 8'(d);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
